// File: rtl/ddr_buf_pkg.sv
// Shared sizing helpers and writer state type for the multi-channel DDR read line buffer.
package ddr_buf_pkg;

  typedef enum logic {IDLE, FILL} wr_state_t;

  function automatic int calc_ppb(input int dq_width);
    return dq_width * 8 / 16;
  endfunction

  function automatic int calc_bpl(input int h_width, input int dq_width);
    return h_width / calc_ppb(dq_width);
  endfunction

  function automatic int calc_seg(input int h_width, input int dq_width, input int ch_num);
    return calc_bpl(h_width, dq_width) / ch_num;
  endfunction

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_ch_w(input int ch_num);
    return bits_for(ch_num);
  endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line RAM: synchronous write, one-cycle registered read.
module line_buf_sdp #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ddr_rd_mbuf.sv
// Ping-pong line buffer: assembles DDR beats into full lines (split or single channel)
// and streams RGB565 pixels to the display with one cycle of read latency.
module ddr_rd_mbuf
  import ddr_buf_pkg::*;
#(
  parameter int DQ_WIDTH = 32,
  parameter int CH_NUM   = 4,
  parameter int H_WIDTH  = 1280,
  parameter int H_HEIGHT = 720
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vs_in,
  input  logic                           disp_mode,
  input  logic [calc_ch_w(CH_NUM)-1:0]   disp_ch,
  input  logic                           buf_wr_en,
  input  logic [DQ_WIDTH*8-1:0]          buf_wr_data,
  output logic [calc_ch_w(CH_NUM)-1:0]   channel_sel,
  output logic                           axi_wr_buf_wait,
  input  logic                           rd_en,
  output logic [15:0]                    rgb565_out,
  output logic                           pix_valid,
  output logic                           ovf_err,
  output logic                           unf_err
);

  localparam int DW   = DQ_WIDTH * 8;
  localparam int PPB  = calc_ppb(DQ_WIDTH);
  localparam int BPL  = calc_bpl(H_WIDTH, DQ_WIDTH);
  localparam int SEG  = calc_seg(H_WIDTH, DQ_WIDTH, CH_NUM);
  localparam int CH_W = calc_ch_w(CH_NUM);
  localparam int AW   = bits_for(2 * BPL);
  localparam int BW   = bits_for(BPL);
  localparam int PW   = bits_for(H_WIDTH);
  localparam int SW   = bits_for(PPB);
  localparam int LW   = bits_for(H_HEIGHT + 1);

  if ((DW % 16) != 0 || (H_WIDTH % PPB) != 0 || (BPL % CH_NUM) != 0 || BPL < 2 ||
      CH_NUM < 2 || (CH_NUM & (CH_NUM - 1)) != 0) begin : g_bad_cfg
    $error("ddr_rd_mbuf: line width must split exactly into beats and channel segments");
  end

  wr_state_t         state, state_n;
  logic              wbank, rbank;
  logic [1:0]        full, full_n;
  logic [BW-1:0]     beat_cnt, beat_n;
  logic [LW-1:0]     line_cnt;
  logic [PW-1:0]     pix_cnt;
  logic              mode_q, mode_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic              wr_go, wr_last, wait_c;
  logic              rd_hit, rd_last;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DW-1:0]     rd_data;
  logic [SW-1:0]     sel_q;
  logic              hit_q;

  assign wait_c          = (state == IDLE) && (full[wbank] || line_cnt == LW'(H_HEIGHT));
  assign axi_wr_buf_wait = wait_c;

  // IDLE claims the free bank and samples the mode; a beat arriving then is beat 0
  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    mode_n  = mode_q;
    ch_n    = ch_q;
    wr_go   = 1'b0;
    wr_last = 1'b0;
    case (state)
      IDLE: begin
        if (!wait_c) begin
          mode_n  = disp_mode;
          ch_n    = disp_ch;
          beat_n  = '0;
          state_n = FILL;
          if (buf_wr_en) begin
            wr_go  = 1'b1;
            beat_n = BW'(1);
          end
        end
      end
      FILL: begin
        if (buf_wr_en) begin
          wr_go = 1'b1;
          if (beat_cnt == BW'(BPL - 1)) begin
            wr_last = 1'b1;
            beat_n  = '0;
            state_n = IDLE;
          end else begin
            beat_n = beat_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wbank       <= 1'b0;
      beat_cnt    <= '0;
      line_cnt    <= '0;
      mode_q      <= 1'b0;
      ch_q        <= '0;
      channel_sel <= '0;
    end else if (vs_in) begin
      state       <= IDLE;
      wbank       <= 1'b0;
      beat_cnt    <= '0;
      line_cnt    <= '0;
      channel_sel <= '0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_n;
      mode_q      <= mode_n;
      ch_q        <= ch_n;
      channel_sel <= mode_n ? ch_n : CH_W'(beat_n / BW'(SEG));
      if (wr_last) begin
        wbank    <= ~wbank;
        line_cnt <= line_cnt + LW'(1);
      end
    end
  end

  assign rd_hit  = rd_en && full[rbank];
  assign rd_last = rd_hit && (pix_cnt == PW'(H_WIDTH - 1));
  assign wr_addr = (wbank ? AW'(BPL) : AW'(0)) + AW'(beat_cnt);
  assign rd_addr = (rbank ? AW'(BPL) : AW'(0)) + AW'(pix_cnt / PW'(PPB));

  // Writer and reader always own different banks, so both flag updates can land together
  always_comb begin
    full_n = full;
    if (wr_last) full_n[wbank] = 1'b1;
    if (rd_last) full_n[rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= '0;
      rbank     <= 1'b0;
      pix_cnt   <= '0;
      sel_q     <= '0;
      hit_q     <= 1'b0;
      pix_valid <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else if (vs_in) begin
      full      <= '0;
      rbank     <= 1'b0;
      pix_cnt   <= '0;
      hit_q     <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      full      <= full_n;
      pix_valid <= rd_en;
      hit_q     <= rd_hit;
      if (rd_hit) begin
        sel_q   <= SW'(pix_cnt % PW'(PPB));
        pix_cnt <= rd_last ? '0 : pix_cnt + PW'(1);
      end
      if (rd_last) rbank <= ~rbank;
      if (rd_en && !full[rbank]) unf_err <= 1'b1;
      if (buf_wr_en && wait_c) ovf_err <= 1'b1;
    end
  end

  line_buf_sdp #(
    .DEPTH(2 * BPL),
    .WIDTH(DW),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_go && !vs_in),
    .wr_addr(wr_addr),
    .wr_data(buf_wr_data),
    .rd_en  (rd_hit && !vs_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // RAM output is already the pipeline register; underflow reads force a zero pixel
  assign rgb565_out = hit_q ? rd_data[{sel_q, 4'b0000} +: 16] : 16'h0000;

endmodule

// File: tb/tb_ddr_rd_mbuf.sv
// Randomized bench for ddr_rd_mbuf against a pixel-queue model of the line buffer.
module tb_ddr_rd_mbuf;

  localparam int DQ_WIDTH = 32;
  localparam int CH_NUM   = 4;
  localparam int H_WIDTH  = 1280;
  localparam int H_HEIGHT = 4;
  localparam int DW       = DQ_WIDTH * 8;
  localparam int PPB      = DW / 16;
  localparam int BPL      = H_WIDTH / PPB;
  localparam int SEG      = BPL / CH_NUM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs_in = 1'b0;
  logic          disp_mode = 1'b0;
  logic [1:0]    disp_ch = 2'd0;
  logic          buf_wr_en = 1'b0;
  logic [DW-1:0] buf_wr_data = '0;
  logic [1:0]    channel_sel;
  logic          axi_wr_buf_wait;
  logic          rd_en = 1'b0;
  logic [15:0]   rgb565_out;
  logic          pix_valid, ovf_err, unf_err;

  int vectors = 0;
  int miscompares = 0;

  // Model: completed lines as one pixel stream, plus the line being assembled
  logic [15:0] pix_q[$];
  logic [15:0] cur_line[$];
  bit          in_line;
  int          beat;
  int          lines_done;
  bit          mode_l;
  logic [1:0]  ch_l;
  bit          exp_ovf, exp_unf, exp_valid;
  logic [15:0] exp_out;

  always #5 clk = ~clk;

  ddr_rd_mbuf #(
    .DQ_WIDTH(DQ_WIDTH), .CH_NUM(CH_NUM), .H_WIDTH(H_WIDTH), .H_HEIGHT(H_HEIGHT)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .disp_mode(disp_mode), .disp_ch(disp_ch),
    .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data), .channel_sel(channel_sel),
    .axi_wr_buf_wait(axi_wr_buf_wait), .rd_en(rd_en), .rgb565_out(rgb565_out),
    .pix_valid(pix_valid), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int full_lines();
    return (pix_q.size() + H_WIDTH - 1) / H_WIDTH;
  endfunction

  function automatic bit model_wait();
    return !in_line && (full_lines() == 2 || lines_done == H_HEIGHT);
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] pattern_beat(input int i);
    logic [DW-1:0] d;
    logic [1:0]    c;
    logic [13:0]   idx;
    c = 2'(i / SEG);
    for (int k = 0; k < PPB; k++) begin
      idx = 14'(i * PPB + k);
      d[16*k +: 16] = {c, idx};
    end
    return d;
  endfunction

  task automatic model_clear(input bit errors_too);
    pix_q.delete();
    cur_line.delete();
    in_line    = 1'b0;
    beat       = 0;
    lines_done = 0;
    exp_valid  = 1'b0;
    exp_out    = 16'h0;
    if (errors_too) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
  endtask

  task automatic store_beat(input logic [DW-1:0] data);
    for (int k = 0; k < PPB; k++) cur_line.push_back(data[16*k +: 16]);
    beat++;
    if (beat == BPL) begin
      foreach (cur_line[j]) pix_q.push_back(cur_line[j]);
      cur_line.delete();
      in_line = 1'b0;
      beat    = 0;
      lines_done++;
    end
  endtask

  // One clock: drive at the falling edge, check pre-edge outputs, advance model, check results
  task automatic applyStimulus(input bit vs, input bit wr, input logic [DW-1:0] data, input bit rd);
    bit         w;
    logic [1:0] ech;
    vs_in       = vs;
    buf_wr_en   = wr;
    buf_wr_data = data;
    rd_en       = rd;
    #1;
    w = model_wait();
    checkOutput("axi_wr_buf_wait", axi_wr_buf_wait, w);
    if (in_line) begin
      ech = mode_l ? ch_l : 2'(beat / SEG);
      checkOutput("channel_sel", channel_sel, ech);
    end
    if (vs) begin
      model_clear(1'b0);
    end else begin
      exp_valid = rd;
      exp_out   = 16'h0;
      if (rd) begin
        if (pix_q.size() > 0) exp_out = pix_q.pop_front();
        else exp_unf = 1'b1;
      end
      if (!in_line) begin
        if (!w) begin
          in_line = 1'b1;
          mode_l  = disp_mode;
          ch_l    = disp_ch;
          beat    = 0;
          if (wr) store_beat(data);
        end else if (wr) begin
          exp_ovf = 1'b1;
        end
      end else if (wr) begin
        store_beat(data);
      end
    end
    @(negedge clk);
    checkOutput("pix_valid", pix_valid, exp_valid);
    if (exp_valid) checkOutput("rgb565_out", rgb565_out, exp_out);
    checkOutput("ovf_err", ovf_err, exp_ovf);
    checkOutput("unf_err", unf_err, exp_unf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic write_beats(input int n, input bit pat);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      applyStimulus(1'b0, 1'b1, pat ? pattern_beat(i) : rand_beat(), 1'b0);
    end
  endtask

  task automatic read_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic do_reset();
    #2;
    rst       = 1'b0;
    vs_in     = 1'b0;
    buf_wr_en = 1'b0;
    rd_en     = 1'b0;
    #1;
    checkOutput("rst channel_sel", channel_sel, 0);
    checkOutput("rst wait", axi_wr_buf_wait, 0);
    checkOutput("rst rgb565_out", rgb565_out, 0);
    checkOutput("rst pix_valid", pix_valid, 0);
    checkOutput("rst ovf_err", ovf_err, 0);
    checkOutput("rst unf_err", unf_err, 0);
    model_clear(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_clear(1'b1);
    mode_l = 1'b0;
    ch_l   = 2'd0;
    do_reset();
    idle(3);

    $display("[TB] split fill and readback");
    disp_mode = 1'b0;
    write_beats(BPL, 1'b1);
    disp_mode = 1'b1;
    disp_ch   = 2'd2;
    read_pixels(H_WIDTH);

    $display("[TB] single mode with mid-fill mode change");
    write_beats(BPL / 2, 1'b0);
    disp_mode = 1'b0;
    disp_ch   = 2'd1;
    write_beats(BPL / 2, 1'b0);
    idle(2);

    $display("[TB] back-pressure and overflow");
    write_beats(BPL, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, rand_beat(), 1'b0);
    idle(2);
    read_pixels(H_WIDTH);
    idle(2);

    $display("[TB] last write of one bank with last read of the other");
    for (int i = 0; i < H_WIDTH; i++)
      applyStimulus(1'b0, i >= H_WIDTH - BPL, rand_beat(), 1'b1);
    read_pixels(H_WIDTH);

    $display("[TB] frame end and underflow");
    idle(5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] resync, including mid-fill vs_in");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    idle(2);
    write_beats(BPL / 2, 1'b0);
    applyStimulus(1'b1, 1'b1, rand_beat(), 1'b1);
    idle(2);
    write_beats(BPL, 1'b1);
    read_pixels(H_WIDTH);

    $display("[TB] asynchronous reset mid-line");
    write_beats(30, 1'b0);
    do_reset();
    idle(3);
    write_beats(BPL, 1'b0);
    read_pixels(H_WIDTH);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
